// File: rtl/bundle_serializer_if.sv
// Load/stream bundle for the bundle serializer. The master modport is the
// serializer side; the slave modport is the bundle source and stream sink.
interface bundle_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REG    = 6
);
    localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data [NUM_REG];
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_W-1:0]      index;
    logic                  last;

    modport master (
        input  load_valid, load_data, ready,
        output load_ready, valid, data, index, last
    );

    modport slave (
        output load_valid, load_data, ready,
        input  load_ready, valid, data, index, last
    );
endinterface

// File: rtl/bundle_serializer.sv
// Captures a NUM_REG-word bundle in one cycle and drains it one word per beat,
// index 0 first, with a no-bubble reload on the last accepted beat.
//
// state | meaning
// IDLE  | buffer empty, ready to capture a bundle
// SEND  | presenting bundle_buf[idx] on the stream port
module bundle_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REG    = 6
) (
    input logic                 clk,
    input logic                 rst,
    bundle_serializer_if.master bus
);
    localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SEND = 2'b10
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] bundle_buf [NUM_REG];

    logic sending;
    logic at_last;
    logic load_fire;
    logic beat_fire;

    assign sending   = (state == SEND);
    assign at_last   = sending && (idx == LAST_IDX);
    assign beat_fire = sending && bus.ready;
    // Ready may come straight from the sink on the last beat so bundles chain without a gap.
    assign load_fire = bus.load_valid &&
                       ((state == IDLE) || (at_last && bus.ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_fire) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (beat_fire && at_last && !load_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            for (int i = 0; i < NUM_REG; i++) begin
                bundle_buf[i] <= '0;
            end
        end else begin
            if (load_fire) begin
                idx <= '0;
                for (int i = 0; i < NUM_REG; i++) begin
                    bundle_buf[i] <= bus.load_data[i];
                end
            end else if (beat_fire) begin
                idx <= at_last ? '0 : idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        bus.valid      = sending;
        bus.data       = '0;
        bus.index      = '0;
        bus.last       = at_last;
        bus.load_ready = (state == IDLE) || (at_last && bus.ready);
        if (sending) begin
            bus.data  = bundle_buf[idx];
            bus.index = idx;
        end
    end

    // A stalled beat must be presented unchanged until accepted.
    hold_on_stall: assert property (
        @(posedge clk) disable iff (rst)
        (bus.valid && !bus.ready) |=> (bus.valid && $stable(bus.data) && $stable(bus.index))
    );

    legal_state: assert property (
        @(posedge clk) disable iff (rst)
        (state == IDLE) || (state == SEND)
    );
endmodule
